// File: rtl/rng_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rng_arbiter
// Brief    : Round-robin arbiter handing out 64-bit LFSR words to NREQ
//            requesters, one word per grant, with reseed and warm-up.
//            Optional grant statistics counter enabled by RNG_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rng_arbiter #(
   parameter int          NREQ   = 4,
   parameter logic [63:0] SEED   = 64'hFEDCBA9876543210,
   parameter int          WARMUP = 8
) (
   input  logic            clk,
   input  logic            s_rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [63:0]     rnd_out,
   output logic            rnd_valid,
   input  logic            seed_load,
   input  logic [63:0]     seed_in,
   output logic            busy,
   output logic [31:0]     gnt_count
);

   localparam int                c_PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NREQ - 1);
   localparam logic [7:0]        c_WARMUP = 8'(WARMUP);
   localparam logic [NREQ-1:0]   c_ONE    = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      WARM  = 2'd2
   } state_t;

   // One LFSR advance, taps x^64 + x^63 + x^61 + x^60
   function automatic logic [63:0] lfsr_step(input logic [63:0] v);
      return {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
   endfunction

   state_t              r_state;
   state_t              w_state_nxt;
   logic [63:0]         r_s;
   logic [c_PTR_W-1:0]  r_ptr;
   logic [7:0]          r_warm_cnt;

   logic                w_grant;
   logic                w_found;
   logic                w_found_hi;
   logic                w_found_lo;
   logic [c_PTR_W-1:0]  w_win_hi;
   logic [c_PTR_W-1:0]  w_win_lo;
   logic [c_PTR_W-1:0]  w_win;
   logic [c_PTR_W-1:0]  w_ptr_nxt;
   logic [63:0]         w_seed_val;

   // A zero seed would lock the LFSR, so it is replaced by SEED
   assign w_seed_val = (seed_in == 64'd0) ? SEED : seed_in;

   // Round-robin pick: lowest requester at/above the pointer, else lowest below it
   always_comb begin
      w_found_hi = 1'b0;
      w_found_lo = 1'b0;
      w_win_hi   = '0;
      w_win_lo   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (i >= int'(r_ptr)) begin
               w_found_hi = 1'b1;
               w_win_hi   = c_PTR_W'(i);
            end else begin
               w_found_lo = 1'b1;
               w_win_lo   = c_PTR_W'(i);
            end
         end
      end
      w_found   = w_found_hi | w_found_lo;
      w_win     = w_found_hi ? w_win_hi : w_win_lo;
      w_ptr_nxt = (w_win == c_LAST) ? '0 : w_win + 1'b1;
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and grant decision; reseed overrides everything
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      if (seed_load) begin
         w_state_nxt = WARM;
      end else begin
         case (r_state)
            IDLE, SERVE: begin
               w_grant     = w_found;
               w_state_nxt = w_found ? SERVE : IDLE;
            end
            WARM: begin
               if (r_warm_cnt <= 8'd1) begin
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Generator state, warm-up counter, pointer and registered grant outputs
   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         r_s        <= SEED;
         r_ptr      <= '0;
         r_warm_cnt <= 8'd0;
         gnt        <= '0;
         rnd_out    <= 64'd0;
         rnd_valid  <= 1'b0;
      end else begin
         gnt       <= '0;
         rnd_out   <= 64'd0;
         rnd_valid <= 1'b0;
         if (seed_load) begin
            r_s        <= w_seed_val;
            r_warm_cnt <= c_WARMUP;
         end else if (r_state == WARM) begin
            r_s        <= lfsr_step(r_s);
            r_warm_cnt <= r_warm_cnt - 8'd1;
         end else if (w_grant) begin
            gnt       <= c_ONE << w_win;
            rnd_out   <= r_s;
            rnd_valid <= 1'b1;
            r_s       <= lfsr_step(r_s);
            r_ptr     <= w_ptr_nxt;
         end
      end
   end

   assign busy = (r_state == WARM);

`ifdef RNG_ARB_STATS_EN
   logic [31:0] r_gnt_count;

   // Saturating count of served words, cleared only by reset
   always_ff @(posedge clk) begin
      if (!s_rst_n) begin
         r_gnt_count <= 32'd0;
      end else if (w_grant && (r_gnt_count != 32'hFFFF_FFFF)) begin
         r_gnt_count <= r_gnt_count + 32'd1;
      end
   end

   assign gnt_count = r_gnt_count;
`else
   assign gnt_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rng_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rng_arbiter
// Brief    : Self-checking bench for rng_arbiter: vector table plus
//            hand-written reseed-restart and counter sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rng_arbiter;

   localparam int          NREQ   = 4;
   localparam logic [63:0] SEED   = 64'hFEDCBA9876543210;
   localparam int          WARMUP = 8;

   logic            clk = 1'b0;
   logic            s_rst_n;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   logic [63:0]     rnd_out;
   logic            rnd_valid;
   logic            seed_load;
   logic [63:0]     seed_in;
   logic            busy;
   logic [31:0]     gnt_count;

   always #5 clk = ~clk;

   rng_arbiter #(
      .NREQ   (NREQ),
      .SEED   (SEED),
      .WARMUP (WARMUP)
   ) dut (
      .clk       (clk),
      .s_rst_n   (s_rst_n),
      .req       (req),
      .gnt       (gnt),
      .rnd_out   (rnd_out),
      .rnd_valid (rnd_valid),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .busy      (busy),
      .gnt_count (gnt_count)
   );

   typedef struct {
      logic        rst_n;
      logic [3:0]  req;
      logic        sl;
      logic [63:0] si;
      logic [3:0]  eg;
      logic        eb;
      logic [63:0] er;
   } vec_t;

   vec_t        vecs[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_cnt = 32'd0;

   // Reference LFSR: n advances of x^64 + x^63 + x^61 + x^60
   function automatic logic [63:0] adv(input logic [63:0] v, input int n);
      logic [63:0] t;
      t = v;
      for (int i = 0; i < n; i++) t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
      return t;
   endfunction

   task automatic add(input logic r, input logic [3:0] rq, input logic sl,
                      input logic [63:0] si, input logic [3:0] eg,
                      input logic eb, input logic [63:0] er);
      vec_t v;
      v.rst_n = r; v.req = rq; v.sl = sl; v.si = si;
      v.eg = eg; v.eb = eb; v.er = er;
      vecs.push_back(v);
   endtask

   task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", what, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic update_model(input logic r, input logic [3:0] eg);
      if (!r) model_cnt = 32'd0;
      else if (eg != 4'd0) model_cnt = model_cnt + 32'd1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] eg,
                            input logic eb, input logic [63:0] er);
      logic [31:0] ec;
`ifdef RNG_ARB_STATS_EN
      ec = model_cnt;
`else
      ec = 32'd0;
`endif
      check({tag, " gnt"},       64'(gnt),       64'(eg));
      check({tag, " rnd_valid"}, 64'(rnd_valid), 64'(eg != 4'd0));
      check({tag, " rnd_out"},   rnd_out,        er);
      check({tag, " busy"},      64'(busy),      64'(eb));
      check({tag, " gnt_count"}, 64'(gnt_count), 64'(ec));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] sx;
      logic [63:0] sa;
      logic [63:0] sb;
      logic [3:0]  one4;
      int          nbusy;
      bit          fell;

      sx   = 64'h0123_4567_89AB_CDEF;
      sa   = 64'h1111_2222_3333_4444;
      sb   = 64'hDEAD_BEEF_0BAD_F00D;
      one4 = 4'b0001;

      s_rst_n   = 1'b0;
      req       = '0;
      seed_load = 1'b0;
      seed_in   = 64'd0;

      // Reset state, then two single-requester words
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 64'd0);
      add(1, 4'b0001, 0, 0, 4'b0001, 0, 64'hFEDCBA9876543210);
      add(1, 4'b0001, 0, 0, 4'b0001, 0, 64'hFDB97530ECA86420);
      add(1, 4'b0000, 0, 0, 4'b0000, 0, 64'd0);
      // Reset again, then all four requesting for 8 cycles
      add(0, 4'b1111, 0, 0, 4'b0000, 0, 64'd0);
      for (int k = 0; k < 8; k++)
         add(1, 4'b1111, 0, 0, one4 << (k % 4), 0, adv(SEED, k));
      add(1, 4'b0000, 0, 0, 4'b0000, 0, 64'd0);
      // Zero-seed reload together with a request: 8 busy cycles, req ignored
      add(1, 4'b0010, 1, 64'd0, 4'b0000, 1, 64'd0);
      for (int k = 0; k < 7; k++)
         add(1, 4'b0010, 0, 0, 4'b0000, 1, 64'd0);
      add(1, 4'b0010, 0, 0, 4'b0000, 0, 64'd0);
      add(1, 4'b0010, 0, 0, 4'b0010, 0, adv(SEED, 8));
      add(1, 4'b0000, 0, 0, 4'b0000, 0, 64'd0);
      // Reset in the middle of warm-up
      add(1, 4'b0000, 1, sx, 4'b0000, 1, 64'd0);
      add(1, 4'b0000, 0, 0, 4'b0000, 1, 64'd0);
      add(1, 4'b0000, 0, 0, 4'b0000, 1, 64'd0);
      add(0, 4'b0000, 0, 0, 4'b0000, 0, 64'd0);
      add(1, 4'b0100, 0, 0, 4'b0100, 0, SEED);
      // Non-zero seed warm-up, then sparse round-robin
      add(1, 4'b0000, 1, sx, 4'b0000, 1, 64'd0);
      for (int k = 0; k < 7; k++)
         add(1, 4'b0000, 0, 0, 4'b0000, 1, 64'd0);
      add(1, 4'b0000, 0, 0, 4'b0000, 0, 64'd0);
      add(1, 4'b1000, 0, 0, 4'b1000, 0, adv(sx, 8));
      add(1, 4'b1010, 0, 0, 4'b0010, 0, adv(sx, 9));
      add(1, 4'b1010, 0, 0, 4'b1000, 0, adv(sx, 10));
      add(1, 4'b1010, 0, 0, 4'b0010, 0, adv(sx, 11));
      add(1, 4'b0000, 0, 0, 4'b0000, 0, 64'd0);

      step();
      for (int i = 0; i < vecs.size(); i++) begin
         s_rst_n   = vecs[i].rst_n;
         req       = vecs[i].req;
         seed_load = vecs[i].sl;
         seed_in   = vecs[i].si;
         step();
         update_model(vecs[i].rst_n, vecs[i].eg);
         check_all($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eb, vecs[i].er);
      end

      // Reseed during warm-up restarts it with the new seed
      s_rst_n = 1'b0; req = '0; seed_load = 1'b0; seed_in = 64'd0;
      step();
      update_model(1'b0, 4'd0);
      s_rst_n = 1'b1;
      seed_load = 1'b1; seed_in = sa;
      step();
      seed_load = 1'b0;
      step();
      step();
      seed_load = 1'b1; seed_in = sb;
      step();
      seed_load = 1'b0; seed_in = 64'd0;
      check("restart busy after reload", 64'(busy), 64'd1);
      nbusy = 1;
      fell  = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (!busy) begin
            fell = 1'b1;
            break;
         end
         nbusy++;
      end
      check("restart busy fell", 64'(fell), 64'd1);
      check("restart busy cycles", 64'(nbusy), 64'(WARMUP));
      req = 4'b0001;
      step();
      req = 4'b0000;
      update_model(1'b1, 4'b0001);
      check_all("restart grant", 4'b0001, 1'b0, adv(sb, 8));
      step();
      check_all("restart idle", 4'b0000, 1'b0, 64'd0);

`ifdef RNG_ARB_STATS_EN
      // Counter saturates at all-ones
      force dut.r_gnt_count = 32'hFFFF_FFFF;
      step();
      release dut.r_gnt_count;
      req = 4'b0010;
      step();
      req = 4'b0000;
      check("gnt_count saturated", 64'(gnt_count), 64'h0000_0000_FFFF_FFFF);
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rng_arbiter.md
RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 Parameter NREQ, default 4, is the number of requesters sharing the generator (2..8).
REQ-002 Parameter SEED, default 64'hFEDCBA9876543210, is the reset state and zero-seed substitute.
REQ-003 Parameter WARMUP, default 8, is the number of discard advances after a reseed (1..255).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 s_rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 req  input  NREQ  per-requester level request for one 64-bit random word.
REQ-007 gnt  output  NREQ  one-hot registered grant pulse, one cycle per served word.
REQ-008 rnd_out  output  64  random word, valid only while rnd_valid=1.
REQ-009 rnd_valid  output  1  high in exactly the cycles where gnt is non-zero.
REQ-010 seed_load  input  1  single-cycle pulse to reseed the generator.
REQ-011 seed_in  input  64  new seed, sampled when seed_load=1.
REQ-012 busy  output  1  high while warm-up is running; no grants are issued.
REQ-013 gnt_count  output  32  saturating count of words served (see Configuration).

Function
REQ-014 Internal 64-bit state s advances as s <= {s[62:0], s[63]^s[62]^s[60]^s[59]} (taps x^64+x^63+x^61+x^60).
REQ-015 The FSM has states IDLE, SERVE and WARM: IDLE->SERVE when any req=1; SERVE->IDLE when req=0; any state->WARM on seed_load; WARM->IDLE after WARMUP advances.
REQ-016 Grant latency: req sampled high in cycle t produces gnt and rnd_valid in cycle t+1, with rnd_out equal to s as held in cycle t.
REQ-017 s advances exactly once per issued grant and once per WARM cycle, and is otherwise held.
REQ-018 At most one grant is issued per cycle; back-to-back grants are allowed in consecutive cycles.
REQ-019 Arbitration is round-robin: the pointer starts at 0 and, after a grant to i, index (i+1) mod NREQ has highest priority.
REQ-020 A req that stays high after its gnt counts as a new request; a requester drops req in the cycle after gnt if it wants only one word.
REQ-021 Every issued word is distinct in sequence: no two requesters ever receive the same word.
REQ-022 seed_load has priority over req: in that cycle no grant is issued, s <= seed_in (or SEED if seed_in==0), and the warm counter <= WARMUP.
REQ-023 A seed_load during WARM restarts warm-up with the new seed.
REQ-024 busy=1 in every WARM cycle; req is ignored and not queued during WARM.
REQ-025 The first grant is possible in the cycle after busy falls.
REQ-026 When gnt=0, rnd_out is driven 0.

Reset
REQ-027 Reset values: s=SEED, FSM=IDLE, RR pointer=0, gnt=0, rnd_valid=0, rnd_out=0, busy=0, gnt_count=0.
REQ-028 Reset asserted mid-grant or mid-warm-up aborts immediately, and the next cycle shows the reset values.

Configuration
REQ-029 With macro RNG_ARB_STATS_EN defined, gnt_count increments on each grant, saturates at 32'hFFFFFFFF, and clears only on reset.
REQ-030 With RNG_ARB_STATS_EN undefined, gnt_count is tied to 0, has no counter logic, and the port list is unchanged.

Verification
REQ-031 Reset, then req=4'b0001 for 2 cycles -> gnt0 pulses twice; rnd_out=64'hFEDCBA9876543210 then 64'hFDB97530ECA86420.
REQ-032 req=4'b1111 held for 8 cycles after reset -> gnt order 0,1,2,3,0,1,2,3 with 8 consecutive distinct words.
REQ-033 seed_load with seed_in=0 -> busy high for exactly 8 cycles and the state equals SEED advanced 8 times; first grant returns that value.
REQ-034 seed_load and req=4'b0010 in the same cycle -> no gnt in the following cycle; busy=1.
REQ-035 s_rst_n=0 during WARM cycle 3 -> next cycle busy=0, gnt=0, and a following req returns 64'hFEDCBA9876543210.
REQ-036 With RNG_ARB_STATS_EN, 5 grants -> gnt_count=5; with counter forced to 32'hFFFFFFFF, a further grant leaves it unchanged; without the macro -> gnt_count=0 throughout.
